// File: rtl/seq_mult_32_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   state_t    : controller state encoding (2-bit binary)
//   MULT_WIDTH : operand width; the product is twice this wide
//   N_ITER     : number of add/shift iterations per multiply
package seq_mult_32_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int N_ITER     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : seq_mult_32_pkg

// File: rtl/seq_mult_32_rca.sv
// Ripple-carry adder used by the multiplier for each partial-product add.
//   A, B : addends (WIDTH bits)
//   cin  : carry in
//   S    : sum (WIDTH bits)
//   cout : carry out of the most significant bit
module seq_mult_32_rca #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic [WIDTH-1:0] S,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign S[i]       = A[i] ^ B[i] ^ carry[i];
        assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    assign cout = carry[WIDTH];

endmodule : seq_mult_32_rca

// File: rtl/seq_mult_32.sv
// Unsigned WIDTH x WIDTH multi-cycle shift-and-add multiplier.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request, only honoured in IDLE; captures A and B
//   A, B  : multiplicand / multiplier
//   busy  : high while iterations run
//   done  : one-cycle pulse, P holds the finished product
//   P     : registered 2*WIDTH product, held until the next accepted start
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; P holds the last result
// ST_RUN  | one add/shift iteration per clock, N_ITER iterations total
// ST_DONE | done pulse cycle; P is the final product
module seq_mult_32
    import seq_mult_32_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    state_t           state;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] s;
    logic             c;

    // The low half of P still holds unconsumed multiplier bits; bit 0 is
    // the one that decides whether this iteration adds the multiplicand.
    assign addend = P[0] ? m : '0;

    seq_mult_32_rca #(
        .WIDTH (WIDTH)
    ) RCA_32 (
        .A    (P[2*WIDTH-1:WIDTH]),
        .B    (addend),
        .cin  (1'b0),
        .S    (s),
        .cout (c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            P     <= '0;
            m     <= '0;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= A;
                        P     <= {{WIDTH{1'b0}}, B};
                        count <= '0;
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // 65-bit {carry, sum, low half} shifted right by one:
                    // the adder carry lands in the top bit, never dropped.
                    P     <= {c, s, P[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CNT_W'(N_ITER - 1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule : seq_mult_32
